// File: rtl/bram_run_scheduler_if.sv
// Bundle of requester, accessor and status signals around bram_run_scheduler.
// slave  : the scheduler side.
// master : the requesters/accessor side that drives requests and run status.
interface bram_run_scheduler_if #(
    parameter int CNT_BIT = 31,
    parameter int TOTAL_W = 16
);
    logic               req0_i;
    logic [CNT_BIT-1:0] count0_i;
    logic               ack0_o;
    logic               done0_o;
    logic               req1_i;
    logic [CNT_BIT-1:0] count1_i;
    logic               ack1_o;
    logic               done1_o;
    logic               start_run_o;
    logic [CNT_BIT-1:0] run_count_o;
    logic               idle_i;
    logic               done_i;
    logic               busy_o;
    logic               grant_o;
    logic [TOTAL_W-1:0] run_total_o;
    logic               err_o;

    modport slave (
        input  req0_i, count0_i, req1_i, count1_i, idle_i, done_i,
        output ack0_o, done0_o, ack1_o, done1_o, start_run_o, run_count_o,
               busy_o, grant_o, run_total_o, err_o
    );

    modport master (
        output req0_i, count0_i, req1_i, count1_i, idle_i, done_i,
        input  ack0_o, done0_o, ack1_o, done1_o, start_run_o, run_count_o,
               busy_o, grant_o, run_total_o, err_o
    );
endinterface

// File: rtl/bram_run_scheduler.sv
// Round-robin run scheduler in front of the BRAM accessor.
// Two requesters ask for runs of N words; one is granted at a time, the
// accessor is started with the granted count, and its done is returned to
// the granted requester as a one-cycle pulse. A completed-run counter is kept.
// Every output is a register fed from the decode of the current state, so
// outputs trail the state register by one cycle.
// Optional watchdog: define BRAM_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without done_i and raise a sticky err_o.
module bram_run_scheduler #(
    parameter int CNT_BIT = 31,
    parameter int TOTAL_W = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    bram_run_scheduler_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_ptr;
    logic                 r_grant;
    logic                 r_zero;
    logic [CNT_BIT-1:0]   r_run_count;
    logic [TOTAL_W-1:0]   r_total;
    logic                 r_start;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_done0;
    logic                 r_done1;
    logic                 r_busy;

    logic                 w_req0;
    logic                 w_req1;
    logic                 w_win;
    logic [CNT_BIT-1:0]   w_win_count;
    logic                 w_grant_en;
    logic                 w_start;
    logic                 w_ack_any;
    logic                 w_done_any;
    logic                 w_busy;
    logic                 w_to_hit;

`ifdef BRAM_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_err;

    // Watchdog counter: held at zero outside WAIT, so it starts from zero on WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_state == S_WAIT) && !bus.done_i &&
                      (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Sticky error flag: only a reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_to_hit) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`else
    assign w_to_hit  = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Arbitration, next state and output decode of the current state.
    always_comb begin
        // A request seen while its own ack is on the wire is the one just
        // served (zero-count runs return to IDLE that early); ignore it.
        w_req0      = bus.req0_i & ~r_ack0;
        w_req1      = bus.req1_i & ~r_ack1;
        w_win       = (w_req0 && w_req1) ? r_ptr : w_req1;
        w_win_count = w_win ? bus.count1_i : bus.count0_i;
        w_grant_en  = 1'b0;
        w_next      = r_state;

        case (r_state)
            S_IDLE: begin
                if ((w_req0 || w_req1) && bus.idle_i) begin
                    w_grant_en = 1'b1;
                    w_next     = (w_win_count == '0) ? S_DONE : S_START;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.done_i || w_to_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_start    = (r_state == S_START);
        w_ack_any  = w_start || ((r_state == S_DONE) && r_zero);
        w_done_any = (r_state == S_DONE);
        w_busy     = (r_state != S_IDLE);
    end

    // Latch winner index and its count at grant time; run_count_o holds until the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant     <= 1'b0;
            r_run_count <= '0;
            r_zero      <= 1'b0;
        end else if (w_grant_en) begin
            r_grant     <= w_win;
            r_run_count <= w_win_count;
            r_zero      <= (w_win_count == '0);
        end
    end

    // On completion hand priority to the other requester and count the run (wraps).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= 1'b0;
            r_total <= '0;
        end else if (r_state == S_DONE) begin
            r_ptr   <= ~r_grant;
            r_total <= r_total + 1'b1;
        end
    end

    // Registered pulse and status outputs, steered to the granted requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= w_start;
            r_ack0  <= w_ack_any  & ~r_grant;
            r_ack1  <= w_ack_any  &  r_grant;
            r_done0 <= w_done_any & ~r_grant;
            r_done1 <= w_done_any &  r_grant;
            r_busy  <= w_busy;
        end
    end

    assign bus.start_run_o = r_start;
    assign bus.ack0_o      = r_ack0;
    assign bus.ack1_o      = r_ack1;
    assign bus.done0_o     = r_done0;
    assign bus.done1_o     = r_done1;
    assign bus.busy_o      = r_busy;
    assign bus.grant_o     = r_grant;
    assign bus.run_count_o = r_run_count;
    assign bus.run_total_o = r_total;

endmodule
